// File: rtl/uart_sprite_ctrl.sv
// uart_sprite_ctrl: UART-driven movable square sprites drawn over a framed screen.
// Move/home commands wait in a single pending slot and are applied at the next frame tick.
module uart_sprite_ctrl #(
    parameter int NUM_OBJ   = 4,
    parameter int OBJ_SIZE  = 64,
    parameter int STEP      = 4,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int BORDER    = 10,
    parameter int WRAP_MODE = 0
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       blank,
    input  logic       frame_tick,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [1:0] R,
    output logic [1:0] G,
    output logic [1:0] B,
    output logic [1:0] sel,
    output logic       cmd_dropped
);
    typedef enum logic [2:0] {C_UP, C_DOWN, C_LEFT, C_RIGHT, C_HOME} cmd_t;

    logic [9:0] pos_x [NUM_OBJ];
    logic [9:0] pos_y [NUM_OBJ];
    logic       pend_valid;
    cmd_t       pend_cmd;
    logic [1:0] pend_obj;
    logic       is_cmd, is_sel;
    cmd_t       rx_cmd;
    logic [1:0] rx_idx;
    logic       any_hit, border_px;
    logic [1:0] hit_idx, lvl, r_n, g_n, b_n;
    logic [10:0] xe, ye;

    // 11-bit signed intermediate keeps 0 - STEP negative instead of wrapping
    function automatic logic [9:0] step_pos(input logic [9:0] p, input logic dec, input int scr);
        logic signed [10:0] v, lo, hi, s;
        s  = 11'(scr);
        lo = 11'(BORDER);
        hi = 11'(scr - BORDER - OBJ_SIZE);
        v  = dec ? $signed({1'b0, p}) - $signed(11'(STEP)) : $signed({1'b0, p}) + $signed(11'(STEP));
        return WRAP_MODE != 0 ? 10'(v < 0 ? v + s : (v >= s ? v - s : v))
                              : 10'(v < lo ? lo : (v > hi ? hi : v));
    endfunction

    always_comb begin
        rx_idx = 2'(rx_data - 8'h31);
        is_sel = rx_valid && rx_data >= 8'h31 && rx_data < 8'(8'h31 + NUM_OBJ);
        is_cmd = rx_valid && (rx_data inside {8'h77, 8'h73, 8'h61, 8'h64, 8'h68});
        rx_cmd = rx_data == 8'h77 ? C_UP :
                 rx_data == 8'h73 ? C_DOWN :
                 rx_data == 8'h61 ? C_LEFT :
                 rx_data == 8'h64 ? C_RIGHT : C_HOME;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel         <= 2'd0;
            pend_valid  <= 1'b0;
            pend_cmd    <= C_HOME;
            pend_obj    <= 2'd0;
            cmd_dropped <= 1'b0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                pos_x[i] <= 10'(64 + 128 * i);
                pos_y[i] <= 10'd208;
            end
        end else begin
            if (is_sel)
                sel <= rx_idx;
            if (is_cmd) begin
                pend_valid <= 1'b1;
                pend_cmd   <= rx_cmd;
                pend_obj   <= sel;
            end else if (frame_tick)
                pend_valid <= 1'b0;
            if (is_cmd && pend_valid && !frame_tick)
                cmd_dropped <= 1'b1;
            for (int i = 0; i < NUM_OBJ; i++)
                if (frame_tick && pend_valid && pend_obj == 2'(i)) begin
                    pos_x[i] <= pend_cmd == C_HOME  ? 10'(64 + 128 * i) :
                                pend_cmd == C_LEFT  ? step_pos(pos_x[i], 1'b1, SCREEN_W) :
                                pend_cmd == C_RIGHT ? step_pos(pos_x[i], 1'b0, SCREEN_W) : pos_x[i];
                    pos_y[i] <= pend_cmd == C_HOME  ? 10'd208 :
                                pend_cmd == C_UP    ? step_pos(pos_y[i], 1'b1, SCREEN_H) :
                                pend_cmd == C_DOWN  ? step_pos(pos_y[i], 1'b0, SCREEN_H) : pos_y[i];
                end
        end
    end

    // scanning downward leaves the lowest-index hit as the winner
    always_comb begin
        xe      = {1'b0, x};
        ye      = {1'b0, y};
        any_hit = 1'b0;
        hit_idx = 2'd0;
        for (int i = NUM_OBJ - 1; i >= 0; i--)
            if (xe >= {1'b0, pos_x[i]} && xe < {1'b0, pos_x[i]} + 11'(OBJ_SIZE) &&
                ye >= {1'b0, pos_y[i]} && ye < {1'b0, pos_y[i]} + 11'(OBJ_SIZE) &&
                xe < 11'(SCREEN_W) && ye < 11'(SCREEN_H)) begin
                any_hit = 1'b1;
                hit_idx = 2'(i);
            end
        border_px = xe < 11'(BORDER) || xe >= 11'(SCREEN_W - BORDER) ||
                    ye < 11'(BORDER) || ye >= 11'(SCREEN_H - BORDER);
        lvl = hit_idx == sel ? 2'b11 : 2'b01;
        r_n = border_px ? 2'b11 : (any_hit && (hit_idx == 2'd1 || hit_idx == 2'd3) ? lvl : 2'b00);
        g_n = border_px ? 2'b11 : (any_hit && (hit_idx == 2'd0 || hit_idx == 2'd3) ? lvl : 2'b00);
        b_n = border_px ? 2'b11 : (any_hit && hit_idx == 2'd2 ? lvl : 2'b00);
    end

    always_ff @(posedge clk) begin
        if (reset || blank) begin
            R <= 2'b00;
            G <= 2'b00;
            B <= 2'b00;
        end else begin
            R <= r_n;
            G <= g_n;
            B <= b_n;
        end
    end
endmodule

// File: tb/tb_uart_sprite_ctrl.sv
// tb_uart_sprite_ctrl: clamp (4 objects) and wrap (3 objects) instances fed the same stimulus,
// checked each cycle against a behavioural model plus literal scenario expectations.
module tb_uart_sprite_ctrl;
    logic       clk = 1'b0, reset = 1'b1, blank = 1'b1, frame_tick = 1'b0, rx_valid = 1'b0;
    logic [9:0] x = '0, y = '0;
    logic [7:0] rx_data = '0;
    logic [1:0] r0, g0, b0, s0, r1, g1, b1, s1;
    logic       d0, d1;

    always #5 clk = ~clk;

    uart_sprite_ctrl #(.WRAP_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .x(x), .y(y), .blank(blank), .frame_tick(frame_tick),
        .rx_data(rx_data), .rx_valid(rx_valid), .R(r0), .G(g0), .B(b0), .sel(s0), .cmd_dropped(d0));
    uart_sprite_ctrl #(.NUM_OBJ(3), .WRAP_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .x(x), .y(y), .blank(blank), .frame_tick(frame_tick),
        .rx_data(rx_data), .rx_valid(rx_valid), .R(r1), .G(g1), .B(b1), .sel(s1), .cmd_dropped(d1));

    int passed = 0, total = 0;
    int mx[2][4], my[2][4], msel[2], mdrop[2], mpv[2], mpobj[2], erg[2];
    logic [7:0] mpcmd[2];
    int nobj[2] = '{4, 3};
    logic [7:0] tbl[12] = '{"1", "2", "3", "4", "w", "s", "a", "d", "h", "x", 8'h30, 8'h35};

    task automatic chk(string n, int a, int e);
        total++;
        if (a == e) passed++;
        else $display("FAIL %s: got %0d expected %0d", n, a, e);
    endtask

    function automatic int ax(int d, int i);
        return d == 0 ? int'(dut0.pos_x[i]) : int'(dut1.pos_x[i]);
    endfunction
    function automatic int ay(int d, int i);
        return d == 0 ? int'(dut0.pos_y[i]) : int'(dut1.pos_y[i]);
    endfunction

    function automatic int mv(int d, int p, int delta, int scr);
        int v = p + delta;
        if (d == 1) return (v + scr) % scr;
        if (v < 10) return 10;
        if (v > scr - 74) return scr - 74;
        return v;
    endfunction

    // expected {R,G,B} as a 6-bit number
    function automatic int pix(int d, int px, int py, bit bl);
        int lv, m;
        if (bl) return 0;
        if (px < 10 || px >= 630 || py < 10 || py >= 470) return 63;
        for (int i = 0; i < nobj[d]; i++)
            if (px < 640 && py < 480 && px >= mx[d][i] && px < mx[d][i] + 64 &&
                py >= my[d][i] && py < my[d][i] + 64) begin
                lv = (i == msel[d]) ? 3 : 1;
                m = i == 0 ? 2 : (i == 1 ? 4 : (i == 2 ? 1 : 6));
                return ((m & 4) != 0 ? lv * 16 : 0) + ((m & 2) != 0 ? lv * 4 : 0) + ((m & 1) != 0 ? lv : 0);
            end
        return 0;
    endfunction

    task automatic model_edge();
        int o;
        bit c;
        for (int d = 0; d < 2; d++) begin
            erg[d] = reset ? 0 : pix(d, int'(x), int'(y), blank);
            if (reset) begin
                for (int i = 0; i < 4; i++) begin
                    mx[d][i] = 64 + 128 * i;
                    my[d][i] = 208;
                end
                msel[d] = 0; mdrop[d] = 0; mpv[d] = 0; mpobj[d] = 0; mpcmd[d] = "h";
            end else begin
                o = mpobj[d];
                if (frame_tick && mpv[d] != 0)
                    case (mpcmd[d])
                        "w": my[d][o] = mv(d, my[d][o], -4, 480);
                        "s": my[d][o] = mv(d, my[d][o], 4, 480);
                        "a": mx[d][o] = mv(d, mx[d][o], -4, 640);
                        "d": mx[d][o] = mv(d, mx[d][o], 4, 640);
                        default: begin mx[d][o] = 64 + 128 * o; my[d][o] = 208; end
                    endcase
                c = rx_valid && (rx_data == "w" || rx_data == "s" || rx_data == "a" || rx_data == "d" || rx_data == "h");
                if (c) begin
                    if (mpv[d] != 0 && !frame_tick) mdrop[d] = 1;
                    mpv[d] = 1; mpcmd[d] = rx_data; mpobj[d] = msel[d];
                end else if (frame_tick) mpv[d] = 0;
                if (rx_valid && int'(rx_data) >= 49 && int'(rx_data) < 49 + nobj[d])
                    msel[d] = int'(rx_data) - 49;
            end
        end
    endtask

    task automatic compare();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < nobj[d]; i++) begin
                chk($sformatf("d%0d_x%0d", d, i), ax(d, i), mx[d][i]);
                chk($sformatf("d%0d_y%0d", d, i), ay(d, i), my[d][i]);
            end
            chk($sformatf("d%0d_sel", d), d == 0 ? int'(s0) : int'(s1), msel[d]);
            chk($sformatf("d%0d_drop", d), d == 0 ? int'(d0) : int'(d1), mdrop[d]);
            chk($sformatf("d%0d_rgb", d), d == 0 ? int'({r0, g0, b0}) : int'({r1, g1, b1}), erg[d]);
        end
    endtask

    task automatic step(bit rs, bit rv, logic [7:0] data, bit ft);
        reset = rs; rx_valid = rv; rx_data = data; frame_tick = ft;
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    initial begin
        logic [7:0] b;
        int k;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_x0", int'(dut0.pos_x[0]), 64);
        chk("rst_x3", int'(dut0.pos_x[3]), 448);
        chk("rst_y2", int'(dut1.pos_y[2]), 208);
        chk("rst_sel", int'(s0), 0);
        chk("rst_rgb", int'({r0, g0, b0}), 0);
        step(0, 1, "d", 0);
        repeat (3) step(0, 0, 0, 0);
        chk("pretick_x0", int'(dut0.pos_x[0]), 64);
        step(0, 0, 0, 1);
        chk("tick_x0", int'(dut0.pos_x[0]), 68);
        repeat (14) begin step(0, 1, "a", 0); step(0, 0, 0, 1); end
        chk("clamp_x12", int'(dut0.pos_x[0]), 12);
        step(0, 1, "a", 0); step(0, 0, 0, 1);
        chk("clamp_x10", int'(dut0.pos_x[0]), 10);
        chk("wrap_x8", int'(dut1.pos_x[0]), 8);
        step(0, 1, "a", 0); step(0, 0, 0, 1);
        chk("clamp_hold10", int'(dut0.pos_x[0]), 10);
        step(1, 0, 0, 0);
        repeat (53) begin step(0, 1, "w", 0); step(0, 0, 0, 1); end
        chk("wrap_y476", int'(dut1.pos_y[0]), 476);
        chk("clamp_y10", int'(dut0.pos_y[0]), 10);
        step(1, 0, 0, 0);
        step(0, 1, "2", 0); step(0, 1, "s", 0); step(0, 1, "s", 0);
        chk("drop_set", int'(d0), 1);
        step(0, 0, 0, 1);
        chk("obj1_y212", int'(dut0.pos_y[1]), 212);
        chk("obj0_y_same", int'(dut0.pos_y[0]), 208);
        step(1, 0, 0, 0);
        step(0, 1, "a", 0); step(0, 1, "d", 1);
        chk("coinc_x60", int'(dut0.pos_x[0]), 60);
        step(0, 0, 0, 1);
        chk("coinc_x64", int'(dut0.pos_x[0]), 64);
        chk("coinc_nodrop", int'(d0), 0);
        step(0, 1, "4", 0);
        chk("sel4_ok", int'(s0), 3);
        chk("sel4_ignored", int'(s1), 0);
        step(1, 0, 0, 0);
        blank = 0; x = 70; y = 210; step(0, 0, 0, 0);
        chk("pix_obj0", int'({r0, g0, b0}), 12);
        x = 5; y = 5; step(0, 0, 0, 0);
        chk("pix_border", int'({r0, g0, b0}), 63);
        blank = 1; step(0, 0, 0, 0);
        chk("pix_blank", int'({r0, g0, b0}), 0);
        for (int n = 0; n < 5000; n++) begin
            blank = $urandom_range(0, 7) == 0;
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, 3);
                x = 10'(mx[0][k] + $urandom_range(0, 67) - 2);
                y = 10'(my[0][k] + $urandom_range(0, 67) - 2);
            end else begin
                x = 10'($urandom_range(0, 700));
                y = 10'($urandom_range(0, 520));
            end
            b = $urandom_range(0, 9) == 0 ? 8'($urandom) : tbl[$urandom_range(0, 11)];
            step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, b, $urandom_range(0, 9) == 0);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
